ext_mem_sample_server: RTL and testbench
========================================

// Module: ext_mem_sample_server
// PURPOSE
// - Responder end of external_memory_if: serves one write plus one read per sample_tick_i
//   for a sample-rate client (delay line) against a pipelined word-addressed memory
//   controller port (avm_*, Avalon-MM style, e.g. the SDRAM controller).
// - Read result is registered and held on readdata until the following sample_tick_i,
//   when the client samples it.
// PARAMETERS
// - DWIDTH      16    sample/word width
// - AWIDTH      16    client address width (external_memory_if address fields)
// - MEM_AWIDTH  24    controller word-address width; must be >= AWIDTH
// - BASE_ADDR   0     word offset added to every client address (region select)
// - RD_TIMEOUT  1023  max clk cycles in RD_WAIT before the read is abandoned
// PORTS
// - clk_i               in   1           system clock
// - srst_i              in   1           synchronous reset, active-high
// - sample_tick_i       in   1           one-cycle strobe per audio sample
// - mem_if              -    iface       external_memory_if, responder side: write_enable,
//                                        write_address, writedata, read_address in; readdata out
// - avm_address         out  MEM_AWIDTH  controller word address
// - avm_write           out  1           write request
// - avm_writedata       out  DWIDTH      write data
// - avm_read            out  1           read request
// - avm_waitrequest     in   1           controller stall; request held while high
// - avm_readdata        in   DWIDTH      read data
// - avm_readdatavalid   in   1           read data strobe
// - busy_o              out  1           high in any state but IDLE
// - overrun_o           out  1           1-cycle pulse: tick arrived while busy
// - timeout_o           out  1           1-cycle pulse: read abandoned
// - overrun_cnt_o       out  16          see CONFIGURATION
// - timeout_cnt_o       out  16          see CONFIGURATION
// BEHAVIOUR
// - Reset: state IDLE; avm_write/avm_read/avm_address/avm_writedata 0; readdata 0;
//   busy_o, overrun_o, timeout_o 0; drop counter 0; stat counters 0.
// - IDLE + sample_tick_i: capture write_enable, write_address, writedata, read_address.
//   -> WR if write_enable was captured high, else -> RD_REQ.
// - WR: avm_write=1, avm_address=BASE_ADDR+wr_addr (zero-extended, wraps mod 2**MEM_AWIDTH).
//   Hold request while avm_waitrequest=1. Cycle with waitrequest=0: accepted -> RD_REQ.
// - RD_REQ: avm_read=1 at BASE_ADDR+rd_addr, same hold rule; accepted -> RD_WAIT.
//   Fixed write-before-read order: same-address access returns the new data.
// - RD_WAIT: avm_readdatavalid=1 -> readdata<=avm_readdata, -> IDLE.
//   RD_TIMEOUT cycles without valid -> readdata<=0, timeout_o pulse, drop_cnt++, -> IDLE.
// - Stale data: readdatavalid while drop_cnt>0 is discarded and decrements drop_cnt,
//   also inside RD_WAIT. Readdatavalid outside RD_WAIT with drop_cnt=0 is ignored.
// - Latency: readdata updates 1 clk after the accepted readdatavalid, then holds until the
//   next update. The full WR+RD_REQ+RD_WAIT sequence must finish before the next tick.
// - Overrun: sample_tick_i while not IDLE -> overrun_o pulse in the next cycle. The tick is
//   dropped (no capture, no new transaction). The current transaction completes normally.
// - avm_address/avm_writedata are stable while their request is held. Both requests are
//   low outside WR/RD_REQ.
// - srst_i mid-transaction drops requests in the next cycle. Controller-side consequences
//   are owned by the controller, and drop_cnt restarts at 0.
// CONFIGURATION
// - Macro EXT_MEM_SERVER_STATS_EN.
//   - Defined: overrun_cnt_o/timeout_cnt_o count overrun_o/timeout_o pulses, saturate at
//     16'hFFFF, and are cleared only by srst_i.
//   - Undefined: both ports are tied to 0 and no counter logic is built.
//   - All other behaviour is identical.
// TESTING
// - Tick with we=1, wa=5, wd=16'h1234, ra=5, waitrequest=0, readdatavalid 3 clk after
//   read -> write@BASE+5, then read@BASE+5; readdata=16'h1234 before the next tick.
// - waitrequest high 4 clk during WR -> avm_write, avm_address, avm_writedata held
//   unchanged for 5 clk; avm_read stays low until the write is accepted.
// - we=0, ra=16'hFFFF, BASE_ADDR=24'hFFFFFF -> avm_address=24'h00FFFE (wrap), no
//   avm_write pulse.
// - Readdatavalid withheld (RD_TIMEOUT=8) -> timeout_o pulse, readdata=0. The late valid
//   (16'hBEEF) is dropped and the next read returns its own data.
// - Second tick 2 clk after the first while waitrequest=1 -> overrun_o pulse, exactly one
//   write and one read issued. With the macro defined, overrun_cnt_o=1.
// - srst_i during RD_REQ -> avm_read=0 next clk, readdata=0, busy_o=0. The next tick
//   starts a fresh WR.

Source files
------------

// File: rtl/ext_mem_sample_server_if.sv
// external_memory_if: sample-rate client <-> memory responder handshake.
// The client presents one optional write and one read per sample tick.
// The responder returns the read word on readdata and holds it until the next tick.
interface external_memory_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 16
);
  logic              write_enable;
  logic [AWIDTH-1:0] write_address;
  logic [DWIDTH-1:0] writedata;
  logic [AWIDTH-1:0] read_address;
  logic [DWIDTH-1:0] readdata;

  modport responder (
    input  write_enable,
    input  write_address,
    input  writedata,
    input  read_address,
    output readdata
  );

  modport client (
    output write_enable,
    output write_address,
    output writedata,
    output read_address,
    input  readdata
  );
endinterface

// File: rtl/ext_mem_sample_server.sv
// ext_mem_sample_server: per sample tick, issues one optional write followed by one
// read on a pipelined Avalon-MM style word port, and returns the read word to the client.
// Optional saturating overrun/timeout counters are built when EXT_MEM_SERVER_STATS_EN
// is defined; otherwise overrun_cnt_o/timeout_cnt_o are tied to zero.
module ext_mem_sample_server #(
  parameter int unsigned           DWIDTH     = 16,
  parameter int unsigned           AWIDTH     = 16,
  parameter int unsigned           MEM_AWIDTH = 24,
  parameter logic [MEM_AWIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RD_TIMEOUT = 1023
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  sample_tick_i,
  external_memory_if.responder  mem_if,
  output logic [MEM_AWIDTH-1:0] avm_address,
  output logic                  avm_write,
  output logic [DWIDTH-1:0]     avm_writedata,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [DWIDTH-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  timeout_o,
  output logic [15:0]           overrun_cnt_o,
  output logic [15:0]           timeout_cnt_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD_REQ  = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;

  // Timer counts RD_WAIT cycles 0 .. RD_TIMEOUT-1; the last one without valid abandons.
  localparam int unsigned    TW       = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMR_LAST = TW'(RD_TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [MEM_AWIDTH-1:0] avm_address_q, avm_address_d;
  logic [DWIDTH-1:0]     avm_writedata_q, avm_writedata_d;
  logic                  avm_write_q, avm_write_d;
  logic                  avm_read_q, avm_read_d;
  logic [AWIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic [DWIDTH-1:0]     readdata_q, readdata_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  // Outstanding abandoned reads whose late readdatavalid must still be swallowed.
  logic [7:0]            drop_q, drop_d;
  logic                  drop_inc_s;
  logic                  stale_s;

  // Next-state, request and read-return logic
  always_comb begin
    state_d         = state_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    rd_addr_d       = rd_addr_q;
    readdata_d      = readdata_q;
    timer_d         = timer_q;
    timeout_d       = 1'b0;
    drop_inc_s      = 1'b0;
    stale_s         = avm_readdatavalid && (drop_q != 8'd0);
    overrun_d       = sample_tick_i && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (sample_tick_i) begin
          rd_addr_d = mem_if.read_address;
          if (mem_if.write_enable) begin
            state_d         = S_WR;
            avm_address_d   = BASE_ADDR + MEM_AWIDTH'(mem_if.write_address);
            avm_writedata_d = mem_if.writedata;
          end else begin
            state_d       = S_RD_REQ;
            avm_address_d = BASE_ADDR + MEM_AWIDTH'(mem_if.read_address);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          state_d       = S_RD_REQ;
          avm_address_d = BASE_ADDR + MEM_AWIDTH'(rd_addr_q);
        end else begin
          state_d = S_WR;
        end
      end
      S_RD_REQ: begin
        if (!avm_waitrequest) begin
          state_d = S_RD_WAIT;
          timer_d = '0;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid && !stale_s) begin
          readdata_d = avm_readdata;
          state_d    = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          readdata_d = '0;
          timeout_d  = 1'b1;
          drop_inc_s = 1'b1;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A stale valid and a fresh abandonment in the same cycle cancel out.
    if (drop_inc_s && !stale_s) begin
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end else begin
        drop_d = drop_q;
      end
    end else if (stale_s && !drop_inc_s) begin
      drop_d = drop_q - 8'd1;
    end else begin
      drop_d = drop_q;
    end

    avm_write_d = (state_d == S_WR);
    avm_read_d  = (state_d == S_RD_REQ);
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q         <= S_IDLE;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      avm_write_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      rd_addr_q       <= '0;
      readdata_q      <= '0;
      timer_q         <= '0;
      overrun_q       <= 1'b0;
      timeout_q       <= 1'b0;
      drop_q          <= 8'd0;
    end else begin
      state_q         <= state_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      avm_write_q     <= avm_write_d;
      avm_read_q      <= avm_read_d;
      rd_addr_q       <= rd_addr_d;
      readdata_q      <= readdata_d;
      timer_q         <= timer_d;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
      drop_q          <= drop_d;
    end
  end

  assign avm_address     = avm_address_q;
  assign avm_writedata   = avm_writedata_q;
  assign avm_write       = avm_write_q;
  assign avm_read        = avm_read_q;
  assign mem_if.readdata = readdata_q;
  assign busy_o          = (state_q != S_IDLE);
  assign overrun_o       = overrun_q;
  assign timeout_o       = timeout_q;

`ifdef EXT_MEM_SERVER_STATS_EN
  logic [15:0] ovr_cnt_q;
  logic [15:0] tmo_cnt_q;

  // Saturating event counters, advanced together with their pulse, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovr_cnt_q <= 16'd0;
      tmo_cnt_q <= 16'd0;
    end else begin
      if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
        ovr_cnt_q <= ovr_cnt_q + 16'd1;
      end
      if (timeout_d && (tmo_cnt_q != 16'hFFFF)) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
    end
  end

  assign overrun_cnt_o = ovr_cnt_q;
  assign timeout_cnt_o = tmo_cnt_q;
`else
  assign overrun_cnt_o = 16'd0;
  assign timeout_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_ext_mem_sample_server.sv
// Self-checking bench for ext_mem_sample_server: directed vector table, hand-written
// corner sequences and a randomized phase against a client-address memory model.
module tb_ext_mem_sample_server;

  localparam logic [23:0] BASE  = 24'hFFFFFF;
  localparam int          RD_TO = 8;
`ifdef EXT_MEM_SERVER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, tick;
  logic [23:0] avm_address;
  logic        avm_write, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [15:0] avm_writedata, avm_readdata;
  logic        busy_o, overrun_o, timeout_o;
  logic [15:0] overrun_cnt_o, timeout_cnt_o;

  external_memory_if #(.DWIDTH(16), .AWIDTH(16)) mem_if ();

  ext_mem_sample_server #(
    .DWIDTH(16), .AWIDTH(16), .MEM_AWIDTH(24), .BASE_ADDR(BASE), .RD_TIMEOUT(RD_TO)
  ) dut (
    .clk_i(clk), .srst_i(srst), .sample_tick_i(tick), .mem_if(mem_if),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .busy_o(busy_o), .overrun_o(overrun_o),
    .timeout_o(timeout_o), .overrun_cnt_o(overrun_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- controller model ----------------
  typedef struct { logic [15:0] data; longint due; } pend_t;
  typedef struct { logic [23:0] a; logic [15:0] d; } wr_t;
  pend_t       pend_q[$];
  wr_t         wr_log[$];
  logic [23:0] rd_log[$];
  logic [15:0] mem [logic [23:0]];
  int          stall_wr_n = 0, stall_rd_n = 0, rd_lat = 1, withhold_n = 0;
  longint      cyc = 0;
  int          ovr_pulses = 0, tmo_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (overrun_o) ovr_pulses <= ovr_pulses + 1;
    if (timeout_o) tmo_pulses <= tmo_pulses + 1;
  end

  initial begin
    pend_t p;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 16'h0BAD;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = 16'h0BAD;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      avm_waitrequest = 1'b0;
      if (avm_write) begin
        if (stall_wr_n > 0) begin
          avm_waitrequest = 1'b1;
          stall_wr_n--;
        end else begin
          wr_log.push_back('{a: avm_address, d: avm_writedata});
          mem[avm_address] = avm_writedata;
        end
      end else if (avm_read) begin
        if (stall_rd_n > 0) begin
          avm_waitrequest = 1'b1;
          stall_rd_n--;
        end else begin
          rd_log.push_back(avm_address);
          if (withhold_n > 0) begin
            withhold_n--;
            p.data = 16'hBEEF;
            p.due  = cyc + 14;
          end else begin
            p.data = mem.exists(avm_address) ? mem[avm_address] : 16'hDEAD;
            p.due  = cyc + rd_lat;
          end
          pend_q.push_back(p);
        end
      end
    end
  end

  // ---------------- reference model (client-address view) ----------------
  logic [15:0] model_mem [int];

  function automatic logic [15:0] model_read(logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'hDEAD;
  endfunction

  function automatic logic [23:0] mem_addr(logic [15:0] a);
    longint s;
    s = longint'(BASE) + longint'(a);
    return 24'(s % (longint'(1) << 24));
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_tick(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                         input logic [15:0] ra);
    mem_if.write_enable  = we;
    mem_if.write_address = wa;
    mem_if.writedata     = wd;
    mem_if.read_address  = ra;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    mem_if.write_enable  = ~we;
    mem_if.write_address = ~wa;
    mem_if.writedata     = ~wd;
    mem_if.read_address  = ~ra;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("idle_bound", 64'(busy_o), 64'd0);
  endtask

  typedef struct {
    logic we; logic [15:0] wa, wd, ra;
    int sw, sr, lat;
    logic [23:0] wma, rma; logic [15:0] rd; int busy;
  } vec_t;

  function automatic vec_t mk(logic we, logic [15:0] wa, logic [15:0] wd, logic [15:0] ra,
                              int sw, int sr, int lat, logic [23:0] wma, logic [23:0] rma,
                              logic [15:0] rd, int busy);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.sw = sw; v.sr = sr; v.lat = lat;
    v.wma = wma; v.rma = rma; v.rd = rd; v.busy = busy;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int n;
    wr_log.delete();
    rd_log.delete();
    stall_wr_n = v.sw;
    stall_rd_n = v.sr;
    rd_lat     = v.lat;
    do_tick(v.we, v.wa, v.wd, v.ra);
    wait_idle(n);
    if (v.busy >= 0) chk($sformatf("%s_busy", tag), 64'(n), 64'(v.busy));
    chk($sformatf("%s_rdata", tag), 64'(mem_if.readdata), 64'(v.rd));
    chk($sformatf("%s_nwr", tag), 64'(wr_log.size()), v.we ? 64'd1 : 64'd0);
    if (v.we && wr_log.size() == 1) begin
      chk($sformatf("%s_wr_addr", tag), 64'(wr_log[0].a), 64'(v.wma));
      chk($sformatf("%s_wr_data", tag), 64'(wr_log[0].d), 64'(v.wd));
    end
    chk($sformatf("%s_nrd", tag), 64'(rd_log.size()), 64'd1);
    if (rd_log.size() == 1) chk($sformatf("%s_rd_addr", tag), 64'(rd_log[0]), 64'(v.rma));
    if (v.we) model_mem[int'(v.wa)] = v.wd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[7];
    vec_t v;
    int   n;
    logic [15:0] hold_a;
    logic [15:0] hold_d;

    // BASE = 24'hFFFFFF, so client address a maps to (a - 1) mod 2**24.
    vecs[0] = mk(1'b1, 16'd5,     16'h1234, 16'd5,     0, 0, 3, 24'h000004, 24'h000004, 16'h1234, 5);
    vecs[1] = mk(1'b1, 16'd6,     16'hABCD, 16'd5,     4, 0, 1, 24'h000005, 24'h000004, 16'h1234, 7);
    vecs[2] = mk(1'b0, 16'd0,     16'h0000, 16'd6,     0, 2, 2, 24'h000000, 24'h000005, 16'hABCD, 5);
    vecs[3] = mk(1'b1, 16'hFFFF,  16'h5A5A, 16'hFFFF,  1, 1, 1, 24'h00FFFE, 24'h00FFFE, 16'h5A5A, 5);
    vecs[4] = mk(1'b0, 16'd0,     16'h0000, 16'hFFFF,  0, 0, 4, 24'h000000, 24'h00FFFE, 16'h5A5A, 5);
    vecs[5] = mk(1'b1, 16'd0,     16'h0001, 16'd7,     0, 0, 2, 24'hFFFFFF, 24'h000006, 16'hDEAD, 4);
    vecs[6] = mk(1'b0, 16'd0,     16'h0000, 16'd0,     0, 0, 1, 24'h000000, 24'hFFFFFF, 16'h0001, 2);

    srst = 1'b1;
    tick = 1'b0;
    mem_if.write_enable = 1'b0; mem_if.write_address = '0;
    mem_if.writedata = '0; mem_if.read_address = '0;
    repeat (3) @(negedge clk);
    srst = 1'b0;

    // reset state
    chk("rst_avm_write", 64'(avm_write), 64'd0);
    chk("rst_avm_read", 64'(avm_read), 64'd0);
    chk("rst_avm_address", 64'(avm_address), 64'd0);
    chk("rst_avm_writedata", 64'(avm_writedata), 64'd0);
    chk("rst_readdata", 64'(mem_if.readdata), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_overrun", 64'(overrun_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_ovr_cnt", 64'(overrun_cnt_o), 64'd0);
    chk("rst_tmo_cnt", 64'(timeout_cnt_o), 64'd0);

    // directed vector table
    for (int i = 0; i < 7; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // write held under waitrequest for 4 clk: request stable 5 clk, no read meanwhile
    hold_a = 16'd3;
    hold_d = 16'hC0DE;
    wr_log.delete(); rd_log.delete();
    stall_wr_n = 4; stall_rd_n = 0; rd_lat = 2;
    do_tick(1'b1, hold_a, hold_d, hold_a);
    n = 0;
    while (avm_write && n < 20) begin
      chk("hold_addr", 64'(avm_address), 64'(mem_addr(hold_a)));
      chk("hold_data", 64'(avm_writedata), 64'(hold_d));
      chk("hold_no_read", 64'(avm_read), 64'd0);
      n++;
      @(negedge clk);
    end
    chk("hold_cycles", 64'(n), 64'd5);
    wait_idle(n);
    chk("hold_rdata", 64'(mem_if.readdata), 64'(hold_d));
    model_mem[int'(hold_a)] = hold_d;

    // read timeout, then the late valid must be discarded during the next read
    wr_log.delete(); rd_log.delete();
    stall_wr_n = 0; stall_rd_n = 0; rd_lat = 1; withhold_n = 1;
    do_tick(1'b0, 16'd0, 16'd0, 16'd5);
    wait_idle(n);
    chk("tmo_busy", 64'(n), 64'(1 + RD_TO));
    chk("tmo_pulse", 64'(timeout_o), 64'd1);
    chk("tmo_rdata", 64'(mem_if.readdata), 64'd0);
    chk("tmo_late_pending", 64'(pend_q.size()), 64'd1);
    chk("tmo_cnt", 64'(timeout_cnt_o), 64'(STATS));
    v = mk(1'b0, 16'd0, 16'd0, 16'd5, 0, 0, 2, 24'h0, mem_addr(16'd5), model_read(16'd5), -1);
    apply(v, "after_tmo");
    chk("after_tmo_drained", 64'(pend_q.size()), 64'd0);

    // overrun: second tick 2 clk after the first while the write is stalled
    wr_log.delete(); rd_log.delete();
    stall_wr_n = 4; stall_rd_n = 0; rd_lat = 1;
    do_tick(1'b1, 16'd10, 16'h1111, 16'd10);
    @(negedge clk);
    do_tick(1'b1, 16'd11, 16'h2222, 16'd11);
    chk("ovr_pulse", 64'(overrun_o), 64'd1);
    wait_idle(n);
    chk("ovr_nwr", 64'(wr_log.size()), 64'd1);
    chk("ovr_nrd", 64'(rd_log.size()), 64'd1);
    if (wr_log.size() == 1) chk("ovr_wr_addr", 64'(wr_log[0].a), 64'(mem_addr(16'd10)));
    chk("ovr_rdata", 64'(mem_if.readdata), 64'h1111);
    chk("ovr_cnt", 64'(overrun_cnt_o), 64'(STATS));
    model_mem[10] = 16'h1111;

    // synchronous reset while the read request is stalled
    wr_log.delete(); rd_log.delete();
    stall_wr_n = 0; stall_rd_n = 1000; rd_lat = 1;
    do_tick(1'b1, 16'd9, 16'h7777, 16'd9);
    n = 0;
    while (!avm_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("srst_rdreq_seen", 64'(avm_read), 64'd1);
    chk("srst_wr_done", 64'(wr_log.size()), 64'd1);
    model_mem[9] = 16'h7777;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("srst_avm_read", 64'(avm_read), 64'd0);
    chk("srst_avm_write", 64'(avm_write), 64'd0);
    chk("srst_readdata", 64'(mem_if.readdata), 64'd0);
    chk("srst_busy", 64'(busy_o), 64'd0);
    chk("srst_ovr_cnt", 64'(overrun_cnt_o), 64'd0);
    chk("srst_tmo_cnt", 64'(timeout_cnt_o), 64'd0);
    stall_rd_n = 0;
    wr_log.delete(); rd_log.delete();
    do_tick(1'b1, 16'd9, 16'h8888, 16'd9);
    chk("srst_fresh_wr", 64'(avm_write), 64'd1);
    chk("srst_fresh_addr", 64'(avm_address), 64'(mem_addr(16'd9)));
    wait_idle(n);
    chk("srst_fresh_rdata", 64'(mem_if.readdata), 64'h8888);
    model_mem[9] = 16'h8888;

    // randomized transactions against the client-address model
    for (int i = 0; i < 40; i++) begin
      v.we  = 1'($urandom_range(0, 1));
      v.wa  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      v.wd  = 16'($urandom);
      v.ra  = ($urandom_range(0, 1) == 0) ? v.wa : 16'($urandom_range(0, 15));
      v.sw  = int'($urandom_range(0, 3));
      v.sr  = int'($urandom_range(0, 3));
      v.lat = int'($urandom_range(1, 4));
      v.wma = mem_addr(v.wa);
      v.rma = mem_addr(v.ra);
      if (v.we && v.ra == v.wa) v.rd = v.wd;
      else v.rd = model_read(v.ra);
      v.busy = (v.we ? 1 + v.sw : 0) + 1 + v.sr + v.lat;
      apply(v, $sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge clk);
    chk("total_overruns", 64'(ovr_pulses), 64'd1);
    chk("total_timeouts", 64'(tmo_pulses), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
